// File: rtl/adder_resp_capture.sv
`default_nettype none
// ============================================================================
//  Module      : adder_resp_capture
//  Description : Output-side DFT companion for the ripple adder. Registers
//                sum/cout onto the pins in functional mode and captures
//                {cout,sum} into a serial scan chain in test mode.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_resp_capture #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sel,
   input  logic [N-1:0] sum,
   input  logic         cout,
   input  logic         capture,
   input  logic         shift_en,
   input  logic         scan_in,
   output logic [N-1:0] pin_sum,
   output logic         pin_cout,
   output logic         scan_out,
   output logic         busy,
   output logic         done
);

   localparam int              CNT_W    = $clog2(N + 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [N:0]       chain;
   logic [N:0]       chain_nxt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] count_inc;

   // ------------------------------------------------------------------------
   // Functional pin registers: follow the adder only while sel is low.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pin_sum  <= '0;
         pin_cout <= 1'b0;
      end else if (!sel) begin
         pin_sum  <= sum;
         pin_cout <= cout;
      end
   end

   // ------------------------------------------------------------------------
   // Capture/shift state, chain and shift counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         chain <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         chain <= chain_nxt;
         count <= count_nxt;
      end
   end

   assign count_inc = count + CNT_ONE;

   always_comb begin
      state_nxt = state;
      chain_nxt = chain;
      count_nxt = count;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            // Capture takes priority over any shift_en seen in the same cycle.
            if (sel && capture) begin
               chain_nxt = {cout, sum};
               count_nxt = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (!sel) begin
               // Abort keeps the partially shifted chain for inspection.
               count_nxt = '0;
               state_nxt = IDLE;
            end else if (shift_en) begin
               chain_nxt = {scan_in, chain[N:1]};
               count_nxt = count_inc;
               if (count_inc == LAST_CNT) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
            if (!sel) begin
               count_nxt = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign scan_out = chain[0];

endmodule
`default_nettype wire

// File: tb/tb_adder_resp_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_resp_capture
//  Description : Directed + randomized self-checking bench for adder_resp_capture.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder_resp_capture;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sel;
   logic [N-1:0] sum;
   logic         cout;
   logic         capture;
   logic         shift_en;
   logic         scan_in;
   logic [N-1:0] pin_sum;
   logic         pin_cout;
   logic         scan_out;
   logic         busy;
   logic         done;

   int tests = 0;
   int fails = 0;

   // Reference model: a chain word, an operating mode and shifts still owed.
   logic [N-1:0] m_pin_sum;
   logic         m_pin_cout;
   logic [N:0]   m_chain;
   int           m_mode;   // 0 idle, 1 shifting, 2 finished
   int           m_left;

   adder_resp_capture #(.N(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (sel),
      .sum      (sum),
      .cout     (cout),
      .capture  (capture),
      .shift_en (shift_en),
      .scan_in  (scan_in),
      .pin_sum  (pin_sum),
      .pin_cout (pin_cout),
      .scan_out (scan_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pin_sum  = '0;
      m_pin_cout = 1'b0;
      m_chain    = '0;
      m_mode     = 0;
      m_left     = 0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".pin_sum"},  32'(pin_sum),  32'(m_pin_sum));
      chk({tag, ".pin_cout"}, 32'(pin_cout), 32'(m_pin_cout));
      chk({tag, ".scan_out"}, 32'(scan_out), 32'(m_chain[0]));
      chk({tag, ".busy"},     32'(busy),     32'(m_mode == 1));
      chk({tag, ".done"},     32'(done),     32'(m_mode == 2));
   endtask

   // One clock: drive inputs, advance model, sample 1 time unit after the edge.
   task automatic step(input logic s, input logic [N-1:0] sm, input logic co,
                       input logic cap, input logic sh, input logic si);
      sel      = s;
      sum      = sm;
      cout     = co;
      capture  = cap;
      shift_en = sh;
      scan_in  = si;
      if (!s) begin
         m_pin_sum  = sm;
         m_pin_cout = co;
      end
      case (m_mode)
         0: if (s && cap) begin
               m_chain = {co, sm};
               m_left  = N + 1;
               m_mode  = 1;
            end
         1: if (!s) begin
               m_mode = 0;
            end else if (sh) begin
               m_chain = (m_chain >> 1) | ((N+1)'(si) << N);
               m_left  = m_left - 1;
               if (m_left == 0) m_mode = 2;
            end
         default: m_mode = 0;
      endcase
      @(posedge clk);
      #1;
      check_model("step");
   endtask

   // Capture a word, shift it all out (optional pause), collect bits LSB first.
   task automatic run_scan(input logic [N-1:0] sm, input logic co, input logic si,
                           input int pause_after, input int pause_len,
                           output logic [N:0] word, output int done_at);
      int cyc;
      word    = '0;
      done_at = -1;
      cyc     = 0;
      step(1'b1, sm, co, 1'b1, 1'b0, 1'b0);
      word[0] = scan_out;
      for (int i = 1; i <= N + 1; i++) begin
         if (i - 1 == pause_after) begin
            for (int p = 0; p < pause_len; p++) begin
               step(1'b1, ~sm, ~co, (p == 2), 1'b0, si);
               cyc++;
               if (done && done_at < 0) done_at = cyc;
            end
         end
         step(1'b1, sm, co, 1'b0, 1'b1, si);
         cyc++;
         if (done && done_at < 0) done_at = cyc;
         if (i <= N) word[i] = scan_out;
      end
   endtask

   logic [N:0] word;
   int         done_at;

   initial begin
      rst_n = 1'b0; sel = 1'b0; sum = '0; cout = 1'b0;
      capture = 1'b0; shift_en = 1'b0; scan_in = 1'b0;
      model_reset();
      #1;
      check_model("reset0");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Functional mode and hold under sel=1
      step(1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("func.pin_sum", 32'(pin_sum), 32'h1234);
      chk("func.pin_cout", 32'(pin_cout), 32'd1);
      step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold.pin_sum", 32'(pin_sum), 32'h1234);

      // Plain capture and shift
      run_scan(16'hA5C3, 1'b1, 1'b0, 99, 0, word, done_at);
      chk("scan3.word", 32'(word), 32'h1A5C3);
      chk("scan3.done_at", 32'(done_at), 32'd17);
      step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("scan3.done_once", 32'(done), 32'd0);

      // Pause after bit 3 with an ignored capture in the pause
      run_scan(16'hA5C3, 1'b1, 1'b0, 3, 5, word, done_at);
      chk("pause.word", 32'(word), 32'h1A5C3);
      chk("pause.done_at", 32'(done_at), 32'd22);
      step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Abort after 8 shifts, then fresh capture of 0001
      step(1'b1, 16'hA5C3, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 16'hA5C3, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      step(1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("abort.recap0", 32'(scan_out), 32'd1);
      step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("abort.recap1", 32'(scan_out), 32'd0);
      for (int i = 0; i < N; i++) step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // scan_in fill of a zero capture, then an all-ones capture
      run_scan(16'h0000, 1'b0, 1'b1, 99, 0, word, done_at);
      chk("fill.word", 32'(word), 32'h00000);
      chk("fill.bit0", 32'(scan_out), 32'd1);
      step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_scan(16'hFFFF, 1'b1, 1'b1, 99, 0, word, done_at);
      chk("ones.word", 32'(word), 32'h1FFFF);
      step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in mid shift
      step(1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_model("areset");
      #1;
      rst_n = 1'b1;

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 9) != 0), 16'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
